// File: rtl/qsys_serial_bridge_pkg.sv
// Shared types and helpers for the Avalon-MM to serial master bridge.
// States, Avalon response codes and serial frame sizing.
package qsys_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_OUT,
        WAIT_RDY,
        SHIFT_IN,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Frame layout: R/W bit, address, byte-enables, data.
    function automatic int frame_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w / 8 + data_w;
    endfunction

endpackage

// File: rtl/qsys_serial_bridge_if.sv
// Avalon-MM slave bus bundle of the serial bridge.
// The master modport is the bus side, the slave modport the bridge side.
interface qsys_serial_bridge_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                write;
    logic                read;
    logic                chipselect;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;
    logic [1:0]          response;

    modport master (
        output address, writedata, byteenable, write, read, chipselect,
        input  readdata, readdatavalid, waitrequest, response
    );

    modport slave (
        input  address, writedata, byteenable, write, read, chipselect,
        output readdata, readdatavalid, waitrequest, response
    );

endinterface

// File: rtl/qsys_serial_bridge_bit_timer.sv
// Serial bit timer: sclk low then high for CLK_DIV clocks each, counted
// over a programmed number of bit periods.
module serial_bit_timer #(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_sclk,
    output logic             o_rise,
    output logic             o_bit_end,
    output logic             o_done
);

    localparam int CNT_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] END_AT  = CNT_W'(2 * CLK_DIV - 1);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_bits;
    logic [LEN_W-1:0] r_len;
    logic             r_sclk;

    logic w_rise;
    logic w_end;
    logic w_done;

    assign w_rise = r_active && (r_cnt == RISE_AT);
    assign w_end  = r_active && (r_cnt == END_AT);
    assign w_done = w_end && (r_bits == r_len - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_bits   <= '0;
            r_len    <= '0;
            r_sclk   <= 1'b0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_bits   <= '0;
            r_len    <= i_len;
            r_sclk   <= 1'b0;
        end else if (r_active) begin
            if (w_end) begin
                r_cnt  <= '0;
                r_sclk <= 1'b0;
                r_bits <= r_bits + 1'b1;
                if (w_done)
                    r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (w_rise)
                    r_sclk <= 1'b1;
            end
        end
    end

    assign o_sclk    = r_sclk;
    assign o_rise    = w_rise;
    assign o_bit_end = w_end;
    assign o_done    = w_done;

endmodule

// File: rtl/qsys_serial_bridge.sv
// Avalon-MM slave to serial master bridge: one frame per command,
// ready handshake with timeout, MSB-first read data shift-in.
module qsys_serial_bridge
    import qsys_serial_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                 csi_MCLK_clk,
    input  logic                 rsi_MRST_reset,
    qsys_serial_bridge_if.slave  avs,
    output logic                 sclk,
    output logic                 sle,
    output logic                 sdo,
    input  logic                 sdi,
    input  logic                 srdy
);

    localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
    localparam int LEN_W   = $clog2(FRAME_W + 1);
    localparam int TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t               r_state, w_state_nxt;
    logic [FRAME_W-1:0]   r_shift, w_shift_nxt;
    logic [DATA_W-1:0]    r_rx, w_rx_nxt;
    logic [TO_W-1:0]      r_tcnt, w_tcnt_nxt;
    logic                 r_is_wr, w_is_wr_nxt;
    logic                 r_sle, w_sle_nxt;
    logic                 r_sdo, w_sdo_nxt;
    logic                 r_wait, w_wait_nxt;
    logic                 r_rdv, w_rdv_nxt;
    logic [DATA_W-1:0]    r_rdata, w_rdata_nxt;
    logic [1:0]           r_resp, w_resp_nxt;

    logic                 w_accept;
    logic [DATA_W-1:0]    w_wdata;
    logic [FRAME_W-1:0]   w_frame;
    logic                 w_tm_start;
    logic [LEN_W-1:0]     w_tm_len;
    logic                 w_rise;
    logic                 w_bit_end;
    logic                 w_done;

    // Commands are only sampled while waitrequest is low in IDLE.
    assign w_accept = (r_state == IDLE) && !r_wait && avs.chipselect
                      && (avs.read || avs.write);
    assign w_wdata  = avs.write ? avs.writedata : '0;
    assign w_frame  = {avs.write, avs.address, avs.byteenable, w_wdata};

    assign w_tm_start = w_accept
                        || ((r_state == WAIT_RDY) && srdy && !r_is_wr);
    assign w_tm_len   = w_accept ? LEN_W'(FRAME_W) : LEN_W'(DATA_W);

    serial_bit_timer #(
        .CLK_DIV (CLK_DIV),
        .LEN_W   (LEN_W)
    ) u_timer (
        .clk       (csi_MCLK_clk),
        .rst       (rsi_MRST_reset),
        .i_start   (w_tm_start),
        .i_len     (w_tm_len),
        .o_sclk    (sclk),
        .o_rise    (w_rise),
        .o_bit_end (w_bit_end),
        .o_done    (w_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_rx_nxt    = r_rx;
        w_tcnt_nxt  = r_tcnt;
        w_is_wr_nxt = r_is_wr;
        w_sle_nxt   = r_sle;
        w_sdo_nxt   = r_sdo;
        w_rdv_nxt   = 1'b0;
        w_rdata_nxt = r_rdata;
        w_resp_nxt  = r_resp;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT_OUT;
                    w_shift_nxt = w_frame;
                    w_sdo_nxt   = avs.write;
                    w_sle_nxt   = 1'b1;
                    w_is_wr_nxt = avs.write;
                    w_tcnt_nxt  = '0;
                    w_resp_nxt  = RESP_OKAY;
                end
            end
            SHIFT_OUT: begin
                if (w_done) begin
                    w_state_nxt = WAIT_RDY;
                    w_sle_nxt   = 1'b0;
                    w_sdo_nxt   = 1'b0;
                end else if (w_bit_end) begin
                    w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
                    w_sdo_nxt   = r_shift[FRAME_W-2];
                end
            end
            WAIT_RDY: begin
                // srdy on the timeout cycle still counts as success.
                if (srdy) begin
                    w_state_nxt = r_is_wr ? DONE : SHIFT_IN;
                    w_rx_nxt    = '0;
                    w_resp_nxt  = RESP_OKAY;
                end else if (r_tcnt == TO_LAST) begin
                    w_state_nxt = DONE;
                    w_resp_nxt  = RESP_SLVERR;
                    w_rdv_nxt   = !r_is_wr;
                    if (!r_is_wr)
                        w_rdata_nxt = '1;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            SHIFT_IN: begin
                if (w_rise)
                    w_rx_nxt = {r_rx[DATA_W-2:0], sdi};
                if (w_done) begin
                    w_state_nxt = DONE;
                    w_rdv_nxt   = 1'b1;
                    w_rdata_nxt = r_rx;
                    w_resp_nxt  = RESP_OKAY;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_wait_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_rx    <= '0;
            r_tcnt  <= '0;
            r_is_wr <= 1'b0;
            r_sle   <= 1'b0;
            r_sdo   <= 1'b0;
            r_wait  <= 1'b1;
            r_rdv   <= 1'b0;
            r_rdata <= '0;
            r_resp  <= RESP_OKAY;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_rx    <= w_rx_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_is_wr <= w_is_wr_nxt;
            r_sle   <= w_sle_nxt;
            r_sdo   <= w_sdo_nxt;
            r_wait  <= w_wait_nxt;
            r_rdv   <= w_rdv_nxt;
            r_rdata <= w_rdata_nxt;
            r_resp  <= w_resp_nxt;
        end
    end

    assign sle               = r_sle;
    assign sdo               = r_sdo;
    assign avs.waitrequest   = r_wait;
    assign avs.readdatavalid = r_rdv;
    assign avs.readdata      = r_rdata;
    assign avs.response      = r_resp;

endmodule

// File: tb/tb_qsys_serial_bridge.sv
// Directed bench for qsys_serial_bridge: a 32-bit instance (CLK_DIV=2,
// TIMEOUT=16) and a 16-bit instance (CLK_DIV=1) sharing clock and reset.
module tb_qsys_serial_bridge;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic sclk_a, sle_a, sdo_a, sdi_a, srdy_a;
    logic sclk_b, sle_b, sdo_b, sdi_b, srdy_b;

    qsys_serial_bridge_if #(.ADDR_W(8), .DATA_W(32)) ifa ();
    qsys_serial_bridge_if #(.ADDR_W(8), .DATA_W(16)) ifb ();

    qsys_serial_bridge #(
        .ADDR_W(8), .DATA_W(32), .CLK_DIV(2), .TIMEOUT(16)
    ) dut_a (
        .csi_MCLK_clk   (clk),
        .rsi_MRST_reset (rst),
        .avs            (ifa),
        .sclk           (sclk_a),
        .sle            (sle_a),
        .sdo            (sdo_a),
        .sdi            (sdi_a),
        .srdy           (srdy_a)
    );

    qsys_serial_bridge #(
        .ADDR_W(8), .DATA_W(16), .CLK_DIV(1), .TIMEOUT(16)
    ) dut_b (
        .csi_MCLK_clk   (clk),
        .rsi_MRST_reset (rst),
        .avs            (ifb),
        .sclk           (sclk_b),
        .sle            (sle_b),
        .sdo            (sdo_b),
        .sdi            (sdi_b),
        .srdy           (srdy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One command on instance A plus the peripheral side; srdy_dly < 0
    // means srdy is never given.
    task automatic do_txn_a(
        input  logic        wr,
        input  logic        rd,
        input  logic [7:0]  addr,
        input  logic [31:0] wdata,
        input  logic [3:0]  be,
        input  int          srdy_dly,
        input  logic [31:0] rx,
        output logic [63:0] frame,
        output int          nbits,
        output int          sle_cnt,
        output int          rdv_cnt,
        output int          lat,
        output int          rdv_at,
        output logic [31:0] rdata,
        output logic [1:0]  resp,
        output bit          tout
    );
        int   n, k, fend, idx;
        logic ps;
        frame = '0; nbits = 0; sle_cnt = 0; rdv_cnt = 0;
        lat = -1; rdv_at = -1; rdata = '0; resp = 2'b11; tout = 0;
        idx = 31;
        @(negedge clk);
        ifa.chipselect = 1'b1;
        ifa.write      = wr;
        ifa.read       = rd;
        ifa.address    = addr;
        ifa.writedata  = wdata;
        ifa.byteenable = be;
        k = 0;
        while (ifa.waitrequest && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (ifa.waitrequest) tout = 1;
        @(posedge clk);
        #1;
        ifa.chipselect = 1'b0;
        ifa.write      = 1'b0;
        ifa.read       = 1'b0;
        n  = 0;
        ps = 1'b0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (ifa.readdatavalid) rdv_cnt++;
            if (sle_a) begin
                sle_cnt++;
                if (sclk_a && !ps) begin
                    frame = {frame[62:0], sdo_a};
                    nbits++;
                end
            end
            ps = sclk_a;
            if (!sle_a) break;
        end
        if (n >= 2000) tout = 1;
        fend = n;
        if (srdy_dly >= 0) begin
            repeat (srdy_dly) begin
                @(negedge clk);
                n++;
                if (ifa.readdatavalid) rdv_cnt++;
            end
            srdy_a = 1'b1;
            sdi_a  = rx[31];
            @(posedge clk);
            #1;
            srdy_a = 1'b0;
        end
        ps = 1'b0;
        k  = 0;
        while (k < 3000) begin
            @(negedge clk);
            n++;
            k++;
            if (ifa.readdatavalid) begin
                rdv_cnt++;
                rdata = ifa.readdata;
                if (rdv_at < 0) rdv_at = n - fend;
            end
            if (sclk_a && !ps) begin
                idx--;
                if (idx >= 0) sdi_a = rx[idx];
            end
            ps = sclk_a;
            if (!ifa.waitrequest) begin
                lat  = n;
                resp = ifa.response;
                break;
            end
        end
        if (ifa.waitrequest) tout = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ifa.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_a: got %b expected 1", ifa.waitrequest);
        end
        checks++;
        if ({ifa.readdatavalid, ifa.response, ifa.readdata} !== 35'd0) begin
            errors++;
            $display("FAIL rst_rd_a: got rdv=%b resp=%b rdata=%h expected 0",
                     ifa.readdatavalid, ifa.response, ifa.readdata);
        end
        checks++;
        if ({sclk_a, sle_a, sdo_a, sclk_b, sle_b, sdo_b} !== 6'd0) begin
            errors++;
            $display("FAIL rst_serial: got %b%b%b %b%b%b expected all 0",
                     sclk_a, sle_a, sdo_a, sclk_b, sle_b, sdo_b);
        end
        checks++;
        if ({ifb.waitrequest, ifb.readdatavalid, ifb.response} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_b: got wait=%b rdv=%b resp=%b expected 1,0,00",
                     ifb.waitrequest, ifb.readdatavalid, ifb.response);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ifa.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_first: got %b expected 1", ifa.waitrequest);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ifa.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_idle: got %b expected 0", ifa.waitrequest);
        end
    endtask

    task automatic test_write();
        logic [63:0] fr;
        logic [44:0] exp;
        logic [31:0] rd;
        logic [1:0]  rs;
        int nb, sc, rc, lat, ra;
        bit to;
        exp = {1'b1, 8'h12, 4'hF, 32'hDEADBEEF};
        do_txn_a(1'b1, 1'b0, 8'h12, 32'hDEADBEEF, 4'hF, 5, 32'h0,
                 fr, nb, sc, rc, lat, ra, rd, rs, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL wr_timeout: bounded wait expired");
        end
        checks++;
        if (fr[44:0] !== exp || nb != 45) begin
            errors++;
            $display("FAIL wr_frame: got %h (%0d bits) expected %h (45 bits)",
                     fr[44:0], nb, exp);
        end
        checks++;
        if (sc != 180) begin
            errors++;
            $display("FAIL wr_sle_len: got %0d expected 180", sc);
        end
        checks++;
        if (lat != 188) begin
            errors++;
            $display("FAIL wr_latency: got %0d expected 188", lat);
        end
        checks++;
        if (rs !== 2'b00 || rc != 0) begin
            errors++;
            $display("FAIL wr_resp: got resp=%b rdv=%0d expected 00, 0", rs, rc);
        end
    endtask

    task automatic test_read();
        logic [63:0] fr;
        logic [44:0] exp;
        logic [31:0] rd;
        logic [1:0]  rs;
        int nb, sc, rc, lat, ra;
        bit to;
        exp = {1'b0, 8'h34, 4'hF, 32'h00000000};
        do_txn_a(1'b0, 1'b1, 8'h34, 32'hFFFF0000, 4'hF, 3, 32'hA5A50F0F,
                 fr, nb, sc, rc, lat, ra, rd, rs, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL rd_timeout: bounded wait expired");
        end
        checks++;
        if (fr[44:0] !== exp || nb != 45) begin
            errors++;
            $display("FAIL rd_frame: got %h (%0d bits) expected %h (45 bits)",
                     fr[44:0], nb, exp);
        end
        checks++;
        if (rd !== 32'hA5A50F0F || rc != 1) begin
            errors++;
            $display("FAIL rd_data: got %h x%0d expected a5a50f0f x1", rd, rc);
        end
        checks++;
        if (rs !== 2'b00) begin
            errors++;
            $display("FAIL rd_resp: got %b expected 00", rs);
        end
    endtask

    task automatic test_timeout();
        logic [63:0] fr;
        logic [31:0] rd;
        logic [1:0]  rs;
        int nb, sc, rc, lat, ra;
        bit to;
        do_txn_a(1'b0, 1'b1, 8'h56, 32'h0, 4'h3, -1, 32'h0,
                 fr, nb, sc, rc, lat, ra, rd, rs, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL to_bound: bounded wait expired");
        end
        checks++;
        if (rd !== 32'hFFFFFFFF || rc != 1) begin
            errors++;
            $display("FAIL to_data: got %h x%0d expected ffffffff x1", rd, rc);
        end
        checks++;
        if (rs !== 2'b10) begin
            errors++;
            $display("FAIL to_resp: got %b expected 10", rs);
        end
        checks++;
        if (ra != 16) begin
            errors++;
            $display("FAIL to_delay: got %0d expected 16", ra);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] fr;
        logic [44:0] exp;
        logic [31:0] rd;
        logic [1:0]  rs;
        int nb, sc, rc, lat, ra, k, rises;
        bit to;
        logic ps;
        @(negedge clk);
        ifa.chipselect = 1'b1;
        ifa.write      = 1'b1;
        ifa.read       = 1'b0;
        ifa.address    = 8'h77;
        ifa.writedata  = 32'h01234567;
        ifa.byteenable = 4'hF;
        k = 0;
        while (ifa.waitrequest && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        ifa.chipselect = 1'b0;
        ifa.write      = 1'b0;
        rises = 0;
        ps    = 1'b0;
        k     = 0;
        while (rises < 20 && k < 500) begin
            @(negedge clk);
            k++;
            if (sclk_a && !ps) rises++;
            ps = sclk_a;
        end
        checks++;
        if (rises != 20 || sle_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach: got rises=%0d sle=%b expected 20, 1",
                     rises, sle_a);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({sle_a, sclk_a, sdo_a} !== 3'b000) begin
            errors++;
            $display("FAIL mid_async: got sle/sclk/sdo=%b%b%b expected 000",
                     sle_a, sclk_a, sdo_a);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rc  = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifa.readdatavalid || sle_a) rc++;
        end
        checks++;
        if (rc != 0 || ifa.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL mid_quiet: got activity=%0d wait=%b expected 0, 0",
                     rc, ifa.waitrequest);
        end
        exp = {1'b1, 8'h21, 4'h5, 32'h0F0F0F0F};
        do_txn_a(1'b1, 1'b0, 8'h21, 32'h0F0F0F0F, 4'h5, 1, 32'h0,
                 fr, nb, sc, rc, lat, ra, rd, rs, to);
        checks++;
        if (to || fr[44:0] !== exp || rs !== 2'b00 || rc != 0) begin
            errors++;
            $display("FAIL mid_after: got %h resp=%b rdv=%0d to=%b expected %h 00 0 0",
                     fr[44:0], rs, rc, to, exp);
        end
    endtask

    task automatic test_rd_wr_both();
        logic [63:0] fr;
        logic [44:0] exp;
        logic [31:0] rd;
        logic [1:0]  rs;
        int nb, sc, rc, lat, ra;
        bit to;
        exp = {1'b1, 8'h9A, 4'hC, 32'h13579BDF};
        do_txn_a(1'b1, 1'b1, 8'h9A, 32'h13579BDF, 4'hC, 3, 32'hFFFFFFFF,
                 fr, nb, sc, rc, lat, ra, rd, rs, to);
        checks++;
        if (to || fr[44:0] !== exp) begin
            errors++;
            $display("FAIL both_frame: got %h to=%b expected %h", fr[44:0], to, exp);
        end
        checks++;
        if (rc != 0 || rs !== 2'b00) begin
            errors++;
            $display("FAIL both_rdv: got rdv=%0d resp=%b expected 0, 00", rc, rs);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] fr0, fr1;
        logic [26:0] exp0, exp1;
        logic [15:0] rx, rdata;
        logic [1:0]  resp;
        int n, k, f, nb0, nb1, last_rise, bad_per, n_idle, n_sle2;
        int cnt_down, idx, rdv_cnt;
        bit pend, got_rdv;
        logic ps, pl;
        exp0 = {1'b1, 8'h3C, 2'b11, 16'hBEEF};
        exp1 = {1'b0, 8'h5A, 2'b01, 16'h0000};
        rx   = 16'hC3A5;
        fr0 = '0; fr1 = '0; nb0 = 0; nb1 = 0; f = 0;
        last_rise = -1; bad_per = 0; n_idle = -1; n_sle2 = -1;
        cnt_down = -1; idx = 15; rdv_cnt = 0; rdata = '0; resp = 2'b11;
        got_rdv = 0; ps = 1'b0; pl = 1'b0;
        @(negedge clk);
        k = 0;
        while (ifb.waitrequest && k < 50) begin
            @(negedge clk);
            k++;
        end
        ifb.chipselect = 1'b1;
        ifb.write      = 1'b1;
        ifb.read       = 1'b0;
        ifb.address    = 8'h3C;
        ifb.writedata  = 16'hBEEF;
        ifb.byteenable = 2'b11;
        @(posedge clk);
        #1;
        ifb.write      = 1'b0;
        ifb.read       = 1'b1;
        ifb.address    = 8'h5A;
        ifb.writedata  = 16'h1234;
        ifb.byteenable = 2'b01;
        pend = 1;
        n    = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (srdy_b) srdy_b = 1'b0;
            if (cnt_down > 0) begin
                cnt_down--;
            end else if (cnt_down == 0) begin
                srdy_b   = 1'b1;
                sdi_b    = rx[15];
                idx      = 15;
                cnt_down = -1;
            end
            if (sle_b && !pl) begin
                if (f == 1) n_sle2 = n;
                last_rise = -1;
            end
            if (!sle_b && pl) begin
                f++;
                cnt_down = 2;
            end
            if (sclk_b && !ps) begin
                if (sle_b) begin
                    if (f == 0) begin
                        fr0 = {fr0[62:0], sdo_b};
                        nb0++;
                    end else begin
                        fr1 = {fr1[62:0], sdo_b};
                        nb1++;
                    end
                    if (last_rise >= 0 && n - last_rise != 2) bad_per++;
                    last_rise = n;
                end else begin
                    idx--;
                    if (idx >= 0) sdi_b = rx[idx];
                end
            end
            ps = sclk_b;
            pl = sle_b;
            if (ifb.readdatavalid) begin
                rdv_cnt++;
                got_rdv = 1;
                rdata   = ifb.readdata;
                resp    = ifb.response;
            end
            if (!ifb.waitrequest) begin
                if (pend) begin
                    n_idle = n;
                    pend   = 0;
                    @(posedge clk);
                    #1;
                    ifb.chipselect = 1'b0;
                    ifb.read       = 1'b0;
                end else if (got_rdv) begin
                    break;
                end
            end
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL b2b_bound: bounded wait expired");
        end
        checks++;
        if (fr0[26:0] !== exp0 || nb0 != 27) begin
            errors++;
            $display("FAIL b2b_frame0: got %h (%0d bits) expected %h (27 bits)",
                     fr0[26:0], nb0, exp0);
        end
        checks++;
        if (fr1[26:0] !== exp1 || nb1 != 27) begin
            errors++;
            $display("FAIL b2b_frame1: got %h (%0d bits) expected %h (27 bits)",
                     fr1[26:0], nb1, exp1);
        end
        checks++;
        if (n_idle < 0 || n_sle2 != n_idle + 1) begin
            errors++;
            $display("FAIL b2b_accept: got idle=%0d sle2=%0d expected sle2=idle+1",
                     n_idle, n_sle2);
        end
        checks++;
        if (bad_per != 0) begin
            errors++;
            $display("FAIL b2b_sclk_period: got %0d bad periods expected 0", bad_per);
        end
        checks++;
        if (rdata !== 16'hC3A5 || resp !== 2'b00 || rdv_cnt != 1) begin
            errors++;
            $display("FAIL b2b_rdata: got %h resp=%b x%0d expected c3a5 00 x1",
                     rdata, resp, rdv_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        srdy_a = 1'b0; sdi_a = 1'b0;
        srdy_b = 1'b0; sdi_b = 1'b0;
        ifa.chipselect = 1'b0; ifa.write = 1'b0; ifa.read = 1'b0;
        ifa.address = '0; ifa.writedata = '0; ifa.byteenable = '0;
        ifb.chipselect = 1'b0; ifb.write = 1'b0; ifb.read = 1'b0;
        ifb.address = '0; ifb.writedata = '0; ifb.byteenable = '0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_reset_mid();
        test_rd_wr_both();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
